// File: rtl/exc_int_sequencer.sv
// Interrupt/exception sequencer between device IRQs, the M stage and CP0.
// Latches and masks requests, arbitrates, and drives entry/eret redirect sequences.
module exc_int_sequencer #(
  parameter logic [31:0] HANDLER_PC   = 32'h0000_4180,
  parameter logic [5:0]  EDGE_MASK    = 6'b000000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  dev_irq,
  input  logic [5:0]  pend_clr,
  input  logic [5:0]  sr_im,
  input  logic        sr_exl,
  input  logic        sr_ie,
  input  logic        m_valid,
  input  logic [31:0] m_pc,
  input  logic        m_exc,
  input  logic [4:0]  m_exc_code,
  input  logic        m_eret,
  input  logic [31:0] cp0_epc,
  output logic [5:0]  hwint,
  output logic        exl_set,
  output logic        exl_clr,
  output logic        epc_we,
  output logic [31:0] epc_val,
  output logic [4:0]  exc_code,
  output logic        flush,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_ENTER, S_RETURN, S_HOLD} state_t;

  localparam logic [2:0] HOLD_INIT = 3'(FLUSH_CYCLES - 1);

  state_t      state, state_n;
  logic [5:0]  irq_q, irq_qq, edge_lat, pend;
  logic [2:0]  cnt;
  logic [31:0] epc_q, rpc_q;
  logic [4:0]  code_q;
  logic        int_ok, take_entry;

  // Edge bits come from the latch, level bits pass straight through.
  assign pend       = (edge_lat & EDGE_MASK) | (dev_irq & ~EDGE_MASK);
  assign int_ok     = (|(hwint & sr_im)) & sr_ie & ~sr_exl & m_valid;
  assign take_entry = m_exc | int_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q    <= '0;
      irq_qq   <= '0;
      edge_lat <= '0;
      hwint    <= '0;
    end else begin
      irq_q    <= dev_irq;
      irq_qq   <= irq_q;
      // A new rising edge overrides a same-cycle software clear.
      edge_lat <= ((edge_lat & ~pend_clr) | (irq_q & ~irq_qq)) & EDGE_MASK;
      hwint    <= pend;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      epc_q  <= '0;
      rpc_q  <= '0;
      code_q <= '0;
    end else begin
      state <= state_n;
      if (state == S_IDLE) begin
        if (take_entry) begin
          epc_q  <= m_pc;
          code_q <= m_exc ? m_exc_code : '0;
          rpc_q  <= HANDLER_PC;
        end else if (m_eret) begin
          rpc_q  <= cp0_epc;
        end
      end
      if (state == S_ENTER || state == S_RETURN)
        cnt <= HOLD_INIT;
      else if (state == S_HOLD && cnt != '0)
        cnt <= cnt - 3'd1;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (take_entry)  state_n = S_ENTER;
        else if (m_eret) state_n = S_RETURN;
      end
      S_ENTER:  state_n = S_HOLD;
      S_RETURN: state_n = S_HOLD;
      S_HOLD:   if (cnt == '0) state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  assign exl_set     = (state == S_ENTER);
  assign epc_we      = (state == S_ENTER);
  assign exl_clr     = (state == S_RETURN);
  assign busy        = (state != S_IDLE);
  assign flush       = busy;
  assign redirect    = busy;
  assign redirect_pc = rpc_q;
  assign epc_val     = epc_q;
  assign exc_code    = code_q;

endmodule

// File: tb/tb_exc_int_sequencer.sv
// Directed self-checking bench for exc_int_sequencer (bit 0 edge, others level).
module tb_exc_int_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  dev_irq, pend_clr, sr_im;
  logic        sr_exl, sr_ie, m_valid, m_exc, m_eret;
  logic [31:0] m_pc, cp0_epc;
  logic [4:0]  m_exc_code;
  logic [5:0]  hwint;
  logic        exl_set, exl_clr, epc_we, flush, redirect, busy;
  logic [31:0] epc_val, redirect_pc;
  logic [4:0]  exc_code;

  int n_cmp = 0;
  int n_bad = 0;
  int n;

  exc_int_sequencer #(
    .HANDLER_PC  (32'h0000_4180),
    .EDGE_MASK   (6'b000001),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk(clk), .reset(reset), .dev_irq(dev_irq), .pend_clr(pend_clr),
    .sr_im(sr_im), .sr_exl(sr_exl), .sr_ie(sr_ie), .m_valid(m_valid),
    .m_pc(m_pc), .m_exc(m_exc), .m_exc_code(m_exc_code), .m_eret(m_eret),
    .cp0_epc(cp0_epc), .hwint(hwint), .exl_set(exl_set), .exl_clr(exl_clr),
    .epc_we(epc_we), .epc_val(epc_val), .exc_code(exc_code), .flush(flush),
    .redirect(redirect), .redirect_pc(redirect_pc), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; dev_irq = '0; pend_clr = '0; sr_im = '0; sr_exl = 1'b0;
    sr_ie = 1'b0; m_valid = 1'b0; m_pc = '0; m_exc = 1'b0; m_exc_code = '0;
    m_eret = 1'b0; cp0_epc = '0;
    #8;
    chk("rst_busy", busy, 0);
    chk("rst_hwint", hwint, 0);
    chk("rst_redirect", redirect, 0);
    chk("rst_epc_val", epc_val, 0);
    #4 reset = 1'b1;
    step();

    // Level IRQ on line 2
    sr_im = 6'h3F; sr_ie = 1'b1; m_valid = 1'b1; m_pc = 32'h3010;
    dev_irq = 6'b000100;
    step();
    chk("lvl_hwint", hwint, 6'b000100);
    chk("lvl_idle", busy, 0);
    step();
    chk("lvl_exl_set", exl_set, 1);
    chk("lvl_epc_we", epc_we, 1);
    chk("lvl_epc_val", epc_val, 32'h3010);
    chk("lvl_code", exc_code, 0);
    chk("lvl_rpc", redirect_pc, 32'h4180);
    chk("lvl_flush", flush, 1);
    chk("lvl_exl_clr", exl_clr, 0);
    sr_exl = 1'b1; dev_irq = '0;
    n = 1;
    step();
    chk("lvl_set_pulse", exl_set, 0);
    chk("lvl_we_pulse", epc_we, 0);
    chk("lvl_rpc_hold", redirect_pc, 32'h4180);
    while (redirect && n < 10) begin
      n++;
      step();
    end
    chk("lvl_redir_len", n, 3);
    chk("lvl_back_idle", busy, 0);

    // Masking: IM, EXL and m_valid each block entry
    sr_exl = 1'b0; sr_im = 6'b111011; dev_irq = 6'b000100;
    step(); step();
    chk("msk_hwint", hwint, 6'b000100);
    step(); step();
    chk("msk_im", busy, 0);
    sr_im = 6'h3F; sr_exl = 1'b1;
    step(); step();
    chk("msk_exl", busy, 0);
    sr_exl = 1'b0; m_valid = 1'b0;
    step(); step();
    chk("msk_valid", busy, 0);

    // Exception beats a live interrupt
    m_valid = 1'b1; m_exc = 1'b1; m_exc_code = 5'd4; m_pc = 32'h3030;
    step();
    chk("pri_int_code", exc_code, 5'd4);
    chk("pri_int_epc", epc_val, 32'h3030);
    m_exc = 1'b0; sr_exl = 1'b1;
    step(); step(); step();
    chk("pri_int_done", busy, 0);

    // Exception taken with EXL set; interrupt stays pending, no re-entry
    m_exc = 1'b1; m_exc_code = 5'd12; m_pc = 32'h3040;
    step();
    chk("exc_set", exl_set, 1);
    chk("exc_code", exc_code, 5'd12);
    chk("exc_epc", epc_val, 32'h3040);
    m_exc = 1'b0;
    n = 0;
    while (busy && n < 10) begin
      n++;
      step();
    end
    chk("exc_timeout", busy, 0);
    step(); step(); step();
    chk("exc_no_reentry", busy, 0);
    chk("exc_pending", hwint, 6'b000100);
    chk("exc_code_held", exc_code, 5'd12);
    dev_irq = '0;
    step();

    // Edge latch on line 0
    sr_ie = 1'b0;
    dev_irq = 6'b000001;
    step();
    dev_irq = '0;
    step(); step();
    chk("edg_set", hwint[0], 1);
    step(); step(); step();
    chk("edg_sticky", hwint[0], 1);
    dev_irq = 6'b000001;
    step();
    dev_irq = '0; pend_clr = 6'b000001;
    step();
    pend_clr = '0;
    step(); step();
    chk("edg_set_wins", hwint[0], 1);
    pend_clr = 6'b000001;
    step();
    pend_clr = '0;
    step();
    chk("edg_cleared", hwint[0], 0);

    // Eret
    m_eret = 1'b1; cp0_epc = 32'h3020;
    step();
    chk("ret_clr", exl_clr, 1);
    chk("ret_set", exl_set, 0);
    chk("ret_we", epc_we, 0);
    chk("ret_rpc", redirect_pc, 32'h3020);
    chk("ret_flush", flush, 1);
    m_eret = 1'b0;
    step();
    chk("ret_hold1", busy, 1);
    chk("ret_clr_pulse", exl_clr, 0);
    chk("ret_rpc_hold", redirect_pc, 32'h3020);
    step();
    chk("ret_hold2", busy, 1);
    step();
    chk("ret_idle", busy, 0);

    // Async reset during HOLD, then normal re-entry
    sr_ie = 1'b1; sr_exl = 1'b0; m_pc = 32'h3050; dev_irq = 6'b000100;
    step(); step(); step();
    chk("rst_in_hold", busy, 1);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_redirect", redirect, 0);
    chk("rst_mid_flush", flush, 0);
    chk("rst_mid_hwint", hwint, 0);
    chk("rst_mid_epc", epc_val, 0);
    step();
    reset = 1'b1;
    step();
    chk("post_hwint", hwint, 6'b000100);
    step();
    chk("post_set", exl_set, 1);
    chk("post_epc", epc_val, 32'h3050);
    chk("post_rpc", redirect_pc, 32'h4180);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
